// File: rtl/ctrl_fsm_pkg.sv
// ctrl_fsm_pkg: shared definitions for the core control sequencer.
//   - 5-bit opcode constants driven onto the ALU opcode bus
//   - ctrl_state_t: sequencer states
//   - opcode classification helpers used by the sequencer
package ctrl_fsm_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] kADD  = 5'h00;
  localparam logic [OP_W-1:0] kSUB  = 5'h01;
  localparam logic [OP_W-1:0] kAND  = 5'h02;
  localparam logic [OP_W-1:0] kXOR  = 5'h03;
  localparam logic [OP_W-1:0] kSLL  = 5'h04;
  localparam logic [OP_W-1:0] kSRL  = 5'h05;
  localparam logic [OP_W-1:0] kMOV  = 5'h06;
  localparam logic [OP_W-1:0] kCMP  = 5'h07;
  localparam logic [OP_W-1:0] kLD   = 5'h08;
  localparam logic [OP_W-1:0] kST   = 5'h09;
  localparam logic [OP_W-1:0] kBE   = 5'h0A;
  localparam logic [OP_W-1:0] kBL   = 5'h0B;
  localparam logic [OP_W-1:0] kBG   = 5'h0C;
  localparam logic [OP_W-1:0] kBA   = 5'h0D;
  localparam logic [OP_W-1:0] kHALT = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } ctrl_state_t;

  // Opcodes that end with a register-file write (LD writes after MEM).
  function automatic logic is_writeback(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      kADD, kSUB, kAND, kXOR, kSLL, kSRL, kMOV, kLD: r = 1'b1;
      default:                                       r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      kBE, kBL, kBG, kBA: r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_fsm_branch_resolve.sv
// ctrl_fsm_branch_resolve: combinational branch condition evaluation.
//   op_i      : opcode held in the instruction register
//   lt_flag_i : registered less-than flag
//   z_flag_i  : registered equal flag
//   taken_o   : 1 when op_i is a branch whose condition holds
module ctrl_fsm_branch_resolve
  import ctrl_fsm_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic            lt_flag_i,
  input  logic            z_flag_i,
  output logic            taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      kBE:     taken_o = z_flag_i;
      kBL:     taken_o = lt_flag_i;
      kBG:     taken_o = !lt_flag_i && !z_flag_i;
      kBA:     taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control sequencer for the 8-bit core.
//   clk, rst_n                : core clock, async active-low reset
//   start                     : begin at pc 0 (honoured in IDLE/HALT only)
//   instr_i / imem_rd_o / imem_addr_o : instruction fetch
//   alu_op_o, alu_co_i/lt_i/z_i       : ALU opcode and status
//   rf_ra_o, rf_rb_o, rf_we_o, rf_wa_o, wb_sel_o : register-file control
//   dmem_rd_o, dmem_wr_o, dmem_ack_i  : data memory handshake
//   lut_idx_o, lut_target_i           : branch target lookup
//   pc_o, co/lt/z_flag_o, busy_o, done_o, err_o : status
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | out of reset, waiting for start
// S_FETCH  | imem read strobe at pc
// S_DECODE | latch instruction into ir
// S_EXEC   | ALU op, flag update, branch resolve, pc update
// S_MEM    | LD/ST request held until dmem_ack_i
// S_WB     | one-cycle register-file write
// S_HALT   | stopped (kHALT or illegal opcode), waiting for start
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               imem_rd_o,
  output logic [PC_W-1:0]    imem_addr_o,
  output logic [OP_W-1:0]    alu_op_o,
  input  logic               alu_co_i,
  input  logic               alu_lt_i,
  input  logic               alu_z_i,
  output logic [1:0]         rf_ra_o,
  output logic [1:0]         rf_rb_o,
  output logic               rf_we_o,
  output logic [1:0]         rf_wa_o,
  output logic               wb_sel_o,
  output logic               dmem_rd_o,
  output logic               dmem_wr_o,
  input  logic               dmem_ack_i,
  output logic [3:0]         lut_idx_o,
  input  logic [PC_W-1:0]    lut_target_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               co_flag_o,
  output logic               lt_flag_o,
  output logic               z_flag_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  ctrl_state_t        state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               co_q, co_d;
  logic               lt_q, lt_d;
  logic               z_q, z_d;
  logic               err_q, err_d;
  logic [OP_W-1:0]    op;
  logic               taken;

  assign op = ir_q[INSTR_W-1 -: OP_W];

  ctrl_fsm_branch_resolve u_branch_resolve (
    .op_i      (op),
    .lt_flag_i (lt_q),
    .z_flag_i  (z_q),
    .taken_o   (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      co_q    <= 1'b0;
      lt_q    <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      co_q    <= co_d;
      lt_q    <= lt_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    co_d    = co_q;
    lt_d    = lt_q;
    z_d     = z_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = instr_i;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op == kADD) co_d = alu_co_i;
        if (op == kCMP) begin
          z_d  = alu_z_i;
          lt_d = alu_lt_i;
        end
        // pc wraps naturally at PC_W bits; only kHALT freezes it.
        if (op != kHALT) pc_d = taken ? lut_target_i : pc_q + PC_W'(1);
        if (op == kLD || op == kST)            state_d = S_MEM;
        else if (is_writeback(op))             state_d = S_WB;
        else if (op == kCMP || is_branch(op))  state_d = S_FETCH;
        else if (op == kHALT)                  state_d = S_HALT;
        else begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_MEM: begin
        if (dmem_ack_i) state_d = (op == kLD) ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_rd_o = 1'b0;
    rf_we_o   = 1'b0;
    wb_sel_o  = 1'b0;
    dmem_rd_o = 1'b0;
    dmem_wr_o = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_rd_o = 1'b1;
        busy_o    = 1'b1;
      end
      S_DECODE, S_EXEC: busy_o = 1'b1;
      S_MEM: begin
        busy_o = 1'b1;
        // Request is withdrawn in the same cycle the ack arrives, so it is
        // high only for the wait cycles before completion.
        dmem_rd_o = (op == kLD) && !dmem_ack_i;
        dmem_wr_o = (op == kST) && !dmem_ack_i;
      end
      S_WB: begin
        busy_o   = 1'b1;
        rf_we_o  = 1'b1;
        wb_sel_o = (op == kLD);
      end
      S_HALT:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign alu_op_o    = op;
  assign rf_ra_o     = ir_q[3:2];
  assign rf_rb_o     = ir_q[1:0];
  assign rf_wa_o     = ir_q[3:2];
  assign lut_idx_o   = ir_q[3:0];
  assign co_flag_o   = co_q;
  assign lt_flag_o   = lt_q;
  assign z_flag_o    = z_q;
  assign err_o       = err_q;

endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
Multi-cycle control sequencer for the 8-bit core. It drives the ALU's 5-bit opcode and consumes its co/lt/z outputs. It fetches 9-bit instructions, decodes them, and latches condition flags from ADD/CMP. It resolves BE/BL/BG/BA branches, sequences LD/ST handshakes with data memory, and issues register-file writeback.

Parameters:
PC_W, 10, program counter / instruction address width
INSTR_W, 9, instruction width; op = instr[8:4], ra = instr[3:2], rb = instr[1:0], lut index = instr[3:0]

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin execution at pc 0; sampled only in IDLE or HALT
instr_i  in  INSTR_W  instruction memory data, valid the cycle after imem_rd_o
imem_rd_o  out  1  instruction fetch strobe
imem_addr_o  out  PC_W  fetch address (= pc)
alu_op_o  out  5  opcode to ALU (= ir[8:4])
alu_co_i  in  1  ALU carry out
alu_lt_i  in  1  ALU less-than
alu_z_i  in  1  ALU equal
rf_ra_o  out  2  register-file read port A / write address source
rf_rb_o  out  2  register-file read port B
rf_we_o  out  1  register-file write enable
rf_wa_o  out  2  write address (= ra)
wb_sel_o  out  1  writeback source select: 0 = ALU rslt, 1 = dmem data
dmem_rd_o  out  1  data memory read request
dmem_wr_o  out  1  data memory write request
dmem_ack_i  in  1  data memory completion
lut_idx_o  out  4  branch target LUT index (= ir[3:0])
lut_target_i  in  PC_W  branch target from LUT, combinational
pc_o  out  PC_W  current pc
co_flag_o, lt_flag_o, z_flag_o  out  1 each  latched flags
busy_o  out  1  high in FETCH..WB
done_o  out  1  high while in HALT
err_o  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (async, rst_n = 0): state = IDLE; pc, ir, all flags and err_o = 0; all strobes, busy_o and done_o = 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE/HALT: start = 1 clears pc to 0 and err_o to 0, then moves to FETCH. start in any other state is ignored.
- FETCH: imem_rd_o = 1; next state is DECODE.
- DECODE: ir <= instr_i; next state is EXEC.
- EXEC: alu_op_o is stable from ir.
  - kADD: co_flag <= alu_co_i.
  - kCMP: z_flag <= alu_z_i and lt_flag <= alu_lt_i.
  - No other opcode touches the flags.
- Branch resolution in EXEC:
  - BE is taken if z_flag.
  - BL is taken if lt_flag.
  - BG is taken if !lt_flag && !z_flag.
  - BA is always taken.
  - Flags used are the registered values, not the same-cycle ALU outputs.
- pc update at the end of EXEC: a taken branch sets pc <= lut_target_i; every other case sets pc <= pc + 1, wrapping modulo 2^PC_W. HALT does not update pc.
- Transitions out of EXEC:
  - LD/ST go to MEM.
  - ADD, SUB, AND, XOR, SLL, SRL and MOV go to WB.
  - CMP and branches go to FETCH.
  - kHALT goes to HALT.
  - An undefined opcode sets err_o and goes to HALT.
- MEM: dmem_rd_o (LD) or dmem_wr_o (ST) is held high until the first cycle with dmem_ack_i = 1. dmem_ack_i is sampled only in MEM; an ack outside MEM is ignored. On ack, LD goes to WB and ST goes to FETCH.
- WB: rf_we_o = 1 for exactly one cycle; wb_sel_o = 1 for LD, else 0; next state is FETCH.
- Cycle counts:
  - ALU ops: 4 cycles.
  - CMP/branch: 3 cycles.
  - LD: 5 + (ack wait) cycles.
  - ST: 4 + (ack wait) cycles.
- Reset mid-operation, including MEM with a request outstanding: outputs drop immediately and the pending memory request is abandoned.

Decomposition:
- Shared package (definitions): add kHALT = 5'h1F and typedef enum ctrl_state_t to the existing opcode constants. Add a function is_writeback(op) there.
- Sub-module: branch_resolve, combinational. Inputs are op and the flags; the output is taken.

Test Plan:
1. Hold rst_n = 0 mid-run -> pc_o = 0, busy_o = 0, imem_rd_o = 0 immediately. Then release and pulse start -> the next cycle shows imem_rd_o = 1 with imem_addr_o = 0.
2. ADD ra=1 rb=2 at pc 0, alu_co_i = 1 in EXEC -> FETCH/DECODE/EXEC/WB sequence; rf_we_o high one cycle with rf_wa_o = 1 and wb_sel_o = 0; co_flag_o = 1; pc_o = 1.
3. Branch taken: CMP with alu_z_i = 1, then BE idx 3 with lut_target_i = 10'h040 -> lut_idx_o = 3 and pc_o = 10'h040. Repeat with alu_z_i = 0 -> pc advances by 1.
4. BG after CMP with z = 0, lt = 0 -> taken. After CMP with lt = 1 -> not taken. BA after either -> taken.
5. LD with dmem_ack_i delayed 3 cycles -> dmem_rd_o high exactly 3 cycles, then WB with wb_sel_o = 1. Total instruction length is 8 cycles. A spurious ack during FETCH is ignored.
6. Program at pc 10'h3FF holding ADD -> pc_o wraps to 0. Undefined opcode 5'h1E -> err_o = 1, done_o = 1, busy_o = 0. A start pulse from HALT clears err_o and refetches at pc 0.
